// File: rtl/vid_pkg.sv
// Purpose: shared video timing defaults and width helper for the timing generator.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
// Contents: default raster constants (384x264 total, 256x224 active, /8 pixel clock)
//           and vid_width(), the counter width needed to hold 0..n-1.
package vid_pkg;

    localparam int VID_H_TOTAL   = 384;
    localparam int VID_H_ACTIVE  = 256;
    localparam int VID_HS_START  = 272;
    localparam int VID_HS_WIDTH  = 32;
    localparam int VID_V_TOTAL   = 264;
    localparam int VID_V_ACTIVE  = 224;
    localparam int VID_VS_START  = 240;
    localparam int VID_VS_WIDTH  = 8;
    localparam int VID_CLK_DIV   = 8;
    localparam int VID_SYNC_POL  = 0;
    localparam int VID_VIRQ_LINE = 224;

    // Bits needed to count 0..n-1; never less than one bit so that
    // degenerate sizes (n = 1) still produce a legal vector.
    function automatic int vid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vid_axis_cnt.sv
// Purpose: one raster axis -- wrapping position counter with blank and sync window decode.
// Latency: 0 clk between cnt and blank/sync (decodes are registered from the next count).
// Backpressure: none; advances whenever step is high.
// Ports: clk/rst_n; step (advance this clk); cnt (current position);
//        cnt_nxt (value cnt takes at the next edge); wrap (step at TOTAL-1);
//        blank (cnt >= ACTIVE); sync (cnt in sync window, driven at SYNC_POL).
module vid_axis_cnt
    import vid_pkg::*;
#(
    parameter int TOTAL    = VID_H_TOTAL,
    parameter int ACTIVE   = VID_H_ACTIVE,
    parameter int S_START  = VID_HS_START,
    parameter int S_WIDTH  = VID_HS_WIDTH,
    parameter int SYNC_POL = VID_SYNC_POL,
    parameter int W        = vid_width(TOTAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         step,
    output logic [W-1:0] cnt,
    output logic [W-1:0] cnt_nxt,
    output logic         wrap,
    output logic         blank,
    output logic         sync
);

    logic [31:0] nxt_ext;
    logic        sync_win;

    assign wrap = step && (32'(cnt) == TOTAL - 1);

    always_comb begin
        cnt_nxt = cnt;
        if (wrap) begin
            cnt_nxt = '0;
        end else if (step) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    // Decoding the value the counter is about to take lets the flag registers
    // line up with the counter register in the same cycle.
    assign nxt_ext  = 32'(cnt_nxt);
    assign sync_win = (nxt_ext >= S_START) && (nxt_ext < S_START + S_WIDTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            blank <= 1'b0;
            sync  <= (SYNC_POL == 0);   // inactive level
        end else begin
            cnt   <= cnt_nxt;
            blank <= (nxt_ext >= ACTIVE);
            sync  <= (SYNC_POL != 0) ? sync_win : !sync_win;
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// Purpose: raster timing generator -- pixel enable, h/v counters, sync/blank/de, frame IRQ and vblank NMI.
// Latency: all outputs registered, aligned with hcnt/vcnt in the same cycle; nmi_n lags vblank/nmi_en by 1 clk.
// Backpressure: none; free-running, int_ack only clears the latched IRQ.
// Ports: clk, rst_n (async, active low); int_ack (level, clears irq_n); nmi_en;
//        pix_ce; hcnt/vcnt; hsync/vsync (SYNC_POL); hblank/vblank/de;
//        line_start/frame_start (1-clk pulses); irq_n/nmi_n (active low).
module video_timing_gen
    import vid_pkg::*;
#(
    parameter int H_TOTAL   = VID_H_TOTAL,
    parameter int H_ACTIVE  = VID_H_ACTIVE,
    parameter int HS_START  = VID_HS_START,
    parameter int HS_WIDTH  = VID_HS_WIDTH,
    parameter int V_TOTAL   = VID_V_TOTAL,
    parameter int V_ACTIVE  = VID_V_ACTIVE,
    parameter int VS_START  = VID_VS_START,
    parameter int VS_WIDTH  = VID_VS_WIDTH,
    parameter int CLK_DIV   = VID_CLK_DIV,
    parameter int SYNC_POL  = VID_SYNC_POL,
    parameter int VIRQ_LINE = VID_VIRQ_LINE,
    localparam int HW = vid_width(H_TOTAL),
    localparam int VW = vid_width(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          int_ack,
    input  logic          nmi_en,
    output logic          pix_ce,
    output logic [HW-1:0] hcnt,
    output logic [VW-1:0] vcnt,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic          irq_n,
    output logic          nmi_n
);

    if (H_ACTIVE > H_TOTAL) begin : g_err_h_active
        $error("video_timing_gen: H_ACTIVE exceeds H_TOTAL");
    end
    if (HS_START + HS_WIDTH > H_TOTAL) begin : g_err_hsync
        $error("video_timing_gen: hsync window runs past H_TOTAL");
    end
    if (VS_START + VS_WIDTH > V_TOTAL) begin : g_err_vsync
        $error("video_timing_gen: vsync window runs past V_TOTAL");
    end
    if (VIRQ_LINE >= V_TOTAL) begin : g_err_virq
        $error("video_timing_gen: VIRQ_LINE must be below V_TOTAL");
    end
    if (CLK_DIV < 1 || CLK_DIV > 256) begin : g_err_div
        $error("video_timing_gen: CLK_DIV must be 1..256");
    end

    localparam int DW = vid_width(CLK_DIV);

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_nxt;
    logic [HW-1:0] h_nxt;
    logic [VW-1:0] v_nxt;
    logic          h_wrap;
    logic          v_wrap;
    logic          irq_set;
    logic          de_nxt;

    // pix_ce is registered from the next divider value so it is high exactly
    // while div_q sits at CLK_DIV-1; the counters then step on that same edge.
    assign div_nxt = (32'(div_q) == CLK_DIV - 1) ? '0 : div_q + 1'b1;

    vid_axis_cnt #(
        .TOTAL    (H_TOTAL),
        .ACTIVE   (H_ACTIVE),
        .S_START  (HS_START),
        .S_WIDTH  (HS_WIDTH),
        .SYNC_POL (SYNC_POL)
    ) u_h (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (pix_ce),
        .cnt     (hcnt),
        .cnt_nxt (h_nxt),
        .wrap    (h_wrap),
        .blank   (hblank),
        .sync    (hsync)
    );

    // The vertical axis only moves on a horizontal wrap, so vsync can only
    // change on the edge that brings hcnt back to 0.
    vid_axis_cnt #(
        .TOTAL    (V_TOTAL),
        .ACTIVE   (V_ACTIVE),
        .S_START  (VS_START),
        .S_WIDTH  (VS_WIDTH),
        .SYNC_POL (SYNC_POL)
    ) u_v (
        .clk     (clk),
        .rst_n   (rst_n),
        .step    (h_wrap),
        .cnt     (vcnt),
        .cnt_nxt (v_nxt),
        .wrap    (v_wrap),
        .blank   (vblank),
        .sync    (vsync)
    );

    // Line/frame pulses and the IRQ fire on a wrap, never on reset, so the
    // line in progress at reset release produces no start pulse.
    assign irq_set = h_wrap && (32'(v_nxt) == VIRQ_LINE);
    assign de_nxt  = (32'(h_nxt) < H_ACTIVE) && (32'(v_nxt) < V_ACTIVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q       <= '0;
            pix_ce      <= 1'b0;
            de          <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            irq_n       <= 1'b1;
            nmi_n       <= 1'b1;
        end else begin
            div_q       <= div_nxt;
            pix_ce      <= (32'(div_nxt) == CLK_DIV - 1);
            de          <= de_nxt;
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
            nmi_n       <= !(vblank && nmi_en);
            // A set on the same edge as an acknowledge must not be lost.
            if (irq_set) begin
                irq_n <= 1'b0;
            end else if (int_ack) begin
                irq_n <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Purpose: directed bench for video_timing_gen on a scaled raster plus a tiny /1 high-polarity raster.
// Latency: n/a.
// Backpressure: n/a.
module tb_video_timing_gen;

    // Scaled raster A: 48x20 total, 32x14 active, /4 pixel clock, low-active syncs.
    localparam int FRAME_A = 48 * 20 * 4;   // 3840 clk
    localparam int LINE_A  = 48 * 4;        // 192 clk
    // Raster B: 10x4 total, /1, high-active syncs.
    localparam int FRAME_B = 10 * 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic int_ack = 1'b0;
    logic nmi_en = 1'b0;
    logic int_ack_b = 1'b0;
    logic nmi_en_b = 1'b0;

    logic       pix_ce, hsync, vsync, hblank, vblank, de, line_start, frame_start, irq_n, nmi_n;
    logic [5:0] hcnt;
    logic [4:0] vcnt;
    logic       pix_ce_b, hsync_b, vsync_b, hblank_b, vblank_b, de_b, line_start_b, frame_start_b;
    logic       irq_n_b, nmi_n_b;
    logic [3:0] hcnt_b;
    logic [1:0] vcnt_b;

    int n_chk = 0;
    int n_err = 0;
    int guard;
    int n_de, n_ls, n_fs, n_hs, n_vs, n_pix, n_nmi, n_irq, n_bad;
    int hs_min, hs_max, vs_min, vs_max, last_ls;
    logic prev_vs, prev_irq;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_TOTAL(48), .H_ACTIVE(32), .HS_START(36), .HS_WIDTH(4),
        .V_TOTAL(20), .V_ACTIVE(14), .VS_START(16), .VS_WIDTH(3),
        .CLK_DIV(4), .SYNC_POL(0), .VIRQ_LINE(14)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .int_ack(int_ack), .nmi_en(nmi_en),
        .pix_ce(pix_ce), .hcnt(hcnt), .vcnt(vcnt), .hsync(hsync), .vsync(vsync),
        .hblank(hblank), .vblank(vblank), .de(de), .line_start(line_start),
        .frame_start(frame_start), .irq_n(irq_n), .nmi_n(nmi_n)
    );

    video_timing_gen #(
        .H_TOTAL(10), .H_ACTIVE(8), .HS_START(8), .HS_WIDTH(1),
        .V_TOTAL(4), .V_ACTIVE(3), .VS_START(3), .VS_WIDTH(1),
        .CLK_DIV(1), .SYNC_POL(1), .VIRQ_LINE(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .int_ack(int_ack_b), .nmi_en(nmi_en_b),
        .pix_ce(pix_ce_b), .hcnt(hcnt_b), .vcnt(vcnt_b), .hsync(hsync_b), .vsync(vsync_b),
        .hblank(hblank_b), .vblank(vblank_b), .de(de_b), .line_start(line_start_b),
        .frame_start(frame_start_b), .irq_n(irq_n_b), .nmi_n(nmi_n_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        nmi_en = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_pix_ce", 32'(pix_ce), 0);
        chk("rst_hcnt", 32'(hcnt), 0);
        chk("rst_vcnt", 32'(vcnt), 0);
        chk("rst_hsync", 32'(hsync), 1);
        chk("rst_vsync", 32'(vsync), 1);
        chk("rst_blank", 32'({hblank, vblank, de}), 0);
        chk("rst_pulses", 32'({line_start, frame_start}), 0);
        chk("rst_irq_n", 32'(irq_n), 1);
        chk("rst_nmi_n", 32'(nmi_n), 1);
        chk("rst_b_syncs", 32'({hsync_b, vsync_b, pix_ce_b}), 0);

        // Release: first edge decodes hcnt=0,vcnt=0; first pix_ce on the 3rd edge.
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_de", 32'(de), 1);
        chk("rel_hsync", 32'(hsync), 1);
        chk("rel_line_start", 32'(line_start), 0);
        chk("rel_pix_ce0", 32'(pix_ce), 0);
        chk("rel_b_pix_ce", 32'(pix_ce_b), 1);
        repeat (2) @(negedge clk);
        chk("rel_pix_ce1", 32'(pix_ce), 1);
        chk("rel_hcnt0", 32'(hcnt), 0);
        @(negedge clk);
        chk("rel_hcnt1", 32'(hcnt), 1);
        chk("rel_b_hcnt", 32'(hcnt_b), 3);

        // Frame 0 reaches VIRQ_LINE and raises irq; acknowledge it on line 15.
        guard = 0;
        while (!(vcnt == 15 && line_start) && guard < 2 * FRAME_A) begin
            @(negedge clk);
            guard++;
        end
        chk("irq_frame0_low", 32'(irq_n), 0);
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        chk("irq_frame0_ack", 32'(irq_n), 1);

        guard = 0;
        while (!frame_start && guard < 2 * FRAME_A) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_frame_start", 32'(frame_start), 1);

        // One full frame starting at frame_start.
        n_de = 0; n_ls = 0; n_fs = 0; n_hs = 0; n_vs = 0; n_pix = 0; n_nmi = 0; n_irq = 0; n_bad = 0;
        hs_min = 99; hs_max = 0; vs_min = 99; vs_max = 0; last_ls = -1;
        prev_vs = vsync; prev_irq = irq_n;
        for (int c = 0; c < FRAME_A; c++) begin
            if (de) n_de++;
            if (pix_ce) n_pix++;
            if (frame_start) n_fs++;
            if (!nmi_n) n_nmi++;
            if (!irq_n) n_irq++;
            if (de != ((hcnt < 32) && (vcnt < 14))) n_bad++;
            if (!hsync) begin
                n_hs++;
                if (hcnt < hs_min) hs_min = hcnt;
                if (hcnt > hs_max) hs_max = hcnt;
            end
            if (!vsync) begin
                n_vs++;
                if (vcnt < vs_min) vs_min = vcnt;
                if (vcnt > vs_max) vs_max = vcnt;
            end
            if (vsync != prev_vs && !line_start) n_bad++;
            if (line_start) begin
                n_ls++;
                if (hcnt != 0) n_bad++;
                if (last_ls >= 0 && c - last_ls != LINE_A) n_bad++;
                last_ls = c;
                if (vcnt == 14) begin
                    chk("irq_fall", 32'(irq_n), 0);
                    chk("irq_prev_high", 32'(prev_irq), 1);
                    chk("nmi_lag", 32'(nmi_n), 1);
                    chk("vblank_rise", 32'(vblank), 1);
                end
            end
            if (int_ack) begin
                int_ack = 1'b0;
                chk("irq_ack_clear", 32'(irq_n), 1);
            end else if (line_start && vcnt == 17) begin
                int_ack = 1'b1;
            end
            prev_vs = vsync;
            prev_irq = irq_n;
            @(negedge clk);
        end
        chk("frame_period", 32'(frame_start), 1);
        chk("de_clks", n_de, 32 * 14 * 4);
        chk("pix_ce_count", n_pix, 48 * 20);
        chk("frame_start_count", n_fs, 1);
        chk("line_start_count", n_ls, 20);
        chk("hsync_low_clks", n_hs, 20 * 4 * 4);
        chk("hsync_first", hs_min, 36);
        chk("hsync_last", hs_max, 39);
        chk("vsync_low_clks", n_vs, 3 * LINE_A);
        chk("vsync_first", vs_min, 16);
        chk("vsync_last", vs_max, 18);
        chk("nmi_low_clks", n_nmi, 6 * LINE_A);
        chk("irq_low_clks", n_irq, 3 * LINE_A + 1);
        chk("timing_anomalies", n_bad, 0);

        // nmi_en = 0 keeps nmi_n high for a whole frame; irq acked on line 15.
        nmi_en = 1'b0;
        @(negedge clk);
        n_nmi = 0;
        for (int c = 0; c < FRAME_A; c++) begin
            if (!nmi_n) n_nmi++;
            if (int_ack) int_ack = 1'b0;
            else if (line_start && vcnt == 15) int_ack = 1'b1;
            @(negedge clk);
        end
        chk("nmi_disabled", n_nmi, 0);
        chk("irq_idle", 32'(irq_n), 1);

        // int_ack sampled on the same edge as the set: set wins.
        nmi_en = 1'b1;
        guard = 0;
        while (!(pix_ce && hcnt == 47 && vcnt == 13) && guard < 2 * FRAME_A) begin
            @(negedge clk);
            guard++;
        end
        chk("wait_pre_irq", 32'(pix_ce && hcnt == 47 && vcnt == 13), 1);
        int_ack = 1'b1;
        @(negedge clk);
        chk("irq_set_wins", 32'(irq_n), 0);
        chk("irq_set_vcnt", 32'(vcnt), 14);
        int_ack = 1'b0;
        repeat (5) @(negedge clk);
        chk("irq_hold", 32'(irq_n), 0);

        // Mid-line reset inside the vsync lines: outputs clear without a clock edge.
        guard = 0;
        while (!(vcnt == 16 && hcnt == 20) && guard < 2 * FRAME_A) begin
            @(negedge clk);
            guard++;
        end
        chk("pre_rst_vsync", 32'(vsync), 0);
        chk("pre_rst_nmi", 32'(nmi_n), 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hcnt", 32'(hcnt), 0);
        chk("arst_vcnt", 32'(vcnt), 0);
        chk("arst_syncs", 32'({hsync, vsync}), 3);
        chk("arst_flags", 32'({hblank, vblank, de, pix_ce, line_start, frame_start}), 0);
        chk("arst_irq_nmi", 32'({irq_n, nmi_n}), 3);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("restart_hcnt", 32'(hcnt), 1);
        chk("restart_vcnt", 32'(vcnt), 0);

        // Raster B: /1 divider, high-active syncs, 40 clk frame.
        guard = 0;
        while (!frame_start_b && guard < 5 * FRAME_B) begin
            @(negedge clk);
            guard++;
        end
        chk("b_wait_frame", 32'(frame_start_b), 1);
        n_pix = 0; n_hs = 0; n_vs = 0; n_de = 0; n_fs = 0;
        for (int c = 0; c < FRAME_B; c++) begin
            if (pix_ce_b) n_pix++;
            if (hsync_b) n_hs++;
            if (vsync_b) n_vs++;
            if (de_b) n_de++;
            if (frame_start_b) n_fs++;
            @(negedge clk);
        end
        chk("b_frame_period", 32'(frame_start_b), 1);
        chk("b_pix_ce", n_pix, FRAME_B);
        chk("b_hsync_high", n_hs, 4);
        chk("b_vsync_high", n_vs, 10);
        chk("b_de", n_de, 24);
        chk("b_frame_count", n_fs, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter H_TOTAL, default 384, pixels per line including blanking.
REQ-002 Parameter H_ACTIVE, default 256, visible pixels per line.
REQ-003 Parameter HS_START, default 272, first hcnt value with hsync asserted.
REQ-004 Parameter HS_WIDTH, default 32, hsync length in pixels.
REQ-005 Parameter V_TOTAL, default 264, lines per frame.
REQ-006 Parameter V_ACTIVE, default 224, visible lines per frame.
REQ-007 Parameter VS_START, default 240, first vcnt value with vsync asserted.
REQ-008 Parameter VS_WIDTH, default 8, vsync length in lines.
REQ-009 Parameter CLK_DIV, default 8, clk cycles per pixel (1..256).
REQ-010 Parameter SYNC_POL, default 0, sync polarity: 0 = active-low, 1 = active-high.
REQ-011 Parameter VIRQ_LINE, default 224, line on which the frame interrupt is raised.
REQ-012 Port: clk, input, 1, single system clock; all state changes on its rising edge.
REQ-013 Port: rst_n, input, 1, asynchronous active-low reset.
REQ-014 Port: int_ack, input, 1, level; clears irq_n.
REQ-015 Port: nmi_en, input, 1, enables NMI during vblank.
REQ-016 Port: pix_ce, output, 1, one-clk pixel enable.
REQ-017 Port: hcnt / vcnt, output, HW / VW, pixel and line counters; HW = clog2(H_TOTAL), VW = clog2(V_TOTAL).
REQ-018 Port: hsync / vsync, output, 1, sync pulses at SYNC_POL.
REQ-019 Port: hblank / vblank / de, output, 1, blanking flags, active high; de = !hblank & !vblank.
REQ-020 Port: line_start / frame_start, output, 1, one-clk pulses.
REQ-021 Port: irq_n / nmi_n, output, 1, CPU interrupt lines, active low.

Function
REQ-022 Divider counts 0..CLK_DIV-1 every clk; pix_ce = 1 in the cycle the divider is at CLK_DIV-1; CLK_DIV = 1 -> pix_ce constantly 1.
REQ-023 Counter step (only on clk where pix_ce = 1): hcnt increments and wraps H_TOTAL-1 -> 0; vcnt increments when hcnt wraps, and wraps V_TOTAL-1 -> 0.
REQ-024 All outputs are registered and describe the hcnt/vcnt values present in the same cycle; there is zero latency between the counters and their decodes.
REQ-025 hblank = (hcnt >= H_ACTIVE); vblank = (vcnt >= V_ACTIVE).
REQ-026 hsync is asserted for HS_START <= hcnt < HS_START+HS_WIDTH; vsync is asserted for VS_START <= vcnt < VS_START+VS_WIDTH; vsync changes only together with hcnt = 0.
REQ-027 line_start = 1 for exactly one clk: the first clk where hcnt = 0.
REQ-028 frame_start = 1 for exactly one clk: the first clk where hcnt = 0 and vcnt = 0.
REQ-029 irq_n is driven low on the clk where the counters become hcnt = 0, vcnt = VIRQ_LINE; it stays low until int_ack = 1 is sampled, then returns high on the next clk.
REQ-030 If the irq set event and int_ack = 1 occur in the same clk, set wins and irq_n = 0.
REQ-031 int_ack while irq_n = 1 has no effect; int_ack held high does not block the next frame's set.
REQ-032 nmi_n = !(vblank & nmi_en), registered one clk after its inputs.
REQ-033 Illegal parameter values cause an elaboration error: H_ACTIVE > H_TOTAL, HS_START+HS_WIDTH > H_TOTAL, VS_START+VS_WIDTH > V_TOTAL, VIRQ_LINE >= V_TOTAL, CLK_DIV = 0.

Reset
REQ-034 rst_n = 0 asynchronously clears the divider and sets hcnt = 0, vcnt = 0.
REQ-035 While rst_n = 0: sync outputs are inactive at SYNC_POL; hblank = vblank = de = 0; pix_ce = line_start = frame_start = 0; irq_n = nmi_n = 1.
REQ-036 On the first pix_ce after release, counters advance to hcnt = 1; the frame interrupt is not raised by reset itself, only by reaching VIRQ_LINE.
REQ-037 Assertion of rst_n mid-frame aborts the frame immediately with no partial pulses.

Structure
REQ-038 A shared package vid_pkg holds the default timing constants and a clog2-based width function.
REQ-039 One sub-module, vid_axis_cnt (counter + window decode), is instantiated twice: horizontal and vertical.

Verification
REQ-040 Defaults: release reset, run 2 frames -> frame_start period = 384*264*8 = 811008 clk; line_start period = 3072 clk.
REQ-041 Defaults: hsync low exactly for hcnt 272..303 (256 clk); vsync low for vcnt 240..247; de high for 256x224 pixels per frame.
REQ-042 irq: irq_n falls at vcnt = 224, hcnt = 0; pulse int_ack 1 clk at vcnt = 230 -> irq_n high next clk; int_ack coincident with the set clk -> irq_n stays low.
REQ-043 nmi_en = 1 -> nmi_n low from vcnt 224 to 263 (+1 clk); nmi_en = 0 -> nmi_n constantly 1.
REQ-044 CLK_DIV = 1, SYNC_POL = 1, H_TOTAL = 10, V_TOTAL = 4 -> pix_ce constantly 1, syncs high-active, frame period = 40 clk.
REQ-045 Assert rst_n mid-line at hcnt = 100 -> all outputs take reset values asynchronously; timing restarts from hcnt = 0 after release.
